fp_div: RTL and testbench
=========================

# fp_div

Iterative single-precision IEEE-754 divider that computes `opd1 / opd2`, one quotient bit per cycle behind a start/done handshake. It is the inverse-operation companion to the combinational multiplier in the FPU datapath. It produces the same result word and exception flags as the multiplier (`res`, `nan`, `zero`, `exp_overflow`) plus `div_by_zero`, so both units can share downstream writeback logic.

## Interface
Parameters: none; the format is fixed at binary32.
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `opd1`  in  32  dividend; captured on the accepted `start`
- `opd2`  in  32  divisor; captured on the accepted `start`
- `busy`  out  1  high from the accepted `start` until `done`
- `done`  out  1  one-cycle pulse when the result and flags are valid
- `res`  out  32  result; holds until the next `done`
- `nan`  out  1  result is NaN
- `zero`  out  1  result is +0
- `exp_overflow`  out  1  result is ±inf, from an infinite dividend or exponent overflow
- `div_by_zero`  out  1  finite nonzero value divided by zero

## Operation
- Reset state: IDLE.
- Reset values: `busy`, `done`, `nan`, `zero`, `exp_overflow`, `div_by_zero` = 0; `res` = 0x00000000.
- States: IDLE, DIV, RND.
  - IDLE & `start` & special case → stay IDLE; register the result and pulse `done`.
  - IDLE & `start` & normal → DIV.
  - DIV after 25 iterations → RND.
  - RND → IDLE; register the result and pulse `done`.
- `start` is ignored while `busy` is high. Operands are registered and never re-sampled.
- Subnormal inputs (exp = 0, mant ≠ 0) are flushed to zero before any decision.
- Special-case priority, first match wins:
  1. Either operand is NaN, or 0/0, or inf/inf → `res` = 0x7F800001, `nan` = 1.
  2. opd2 zero, opd1 finite nonzero → `res` = {sign, 0xFF, 0}, `div_by_zero` = 1.
  3. opd1 zero, or opd2 inf → `res` = 0x00000000, `zero` = 1.
  4. opd1 inf → `res` = {sign, 0xFF, 0}, `exp_overflow` = 1.
- sign = `opd1[31]` ^ `opd2[31]`.
- Exponent is a 10-bit signed intermediate: e = e1 − e2 + 127.
- Mantissas are 24 bits, ma = {1, m1} and mb = {1, m2}. If ma < mb, shift ma left by 1 and decrement e, so the quotient lies in [1, 2).
- Restoring division, 25 iterations, MSB first, using a 25-bit partial remainder:
  - quotient bits are q[24] (integer), q[23:1] (fraction), q[0] (guard G);
  - S = (final remainder ≠ 0).
- Rounding in RND is round-to-nearest-even: increment `q[23:1]` if G & (S | q[1]). A rounding carry out of the mantissa sets mantissa = 0 and increments e.
- Final checks:
  - e ≥ 255 → {sign, 0xFF, 0}, `exp_overflow` = 1.
  - e ≤ 0 → 0x00000000, `zero` = 1 (flush; no subnormal output).
  - otherwise `res` = {sign, e[7:0], q[23:1] rounded}.
- Flag behaviour:
  - at most one of `nan`, `zero`, `exp_overflow`, `div_by_zero` is set per result;
  - all four are rewritten on every `done`;
  - all four hold with `res` between `done` pulses.

## Timing
- `start` sampled high at edge N in IDLE:
  - special case: `done` and the result are valid in cycle N+1; `busy` stays 0.
  - normal: `busy` = 1 from N+1 through N+26; iterations occur at edges N+1..N+25; RND at edge N+26; `done` = 1 and the result are valid in cycle N+27, with `busy` = 0 in the same cycle.
- A new `start` in the same cycle as `done` is accepted, since the FSM is already IDLE.
- Back-to-back normal divisions give one result every 27 cycles.
- `done` is high for exactly one cycle.
- `rst` asserted at any time, including mid-DIV:
  - the FSM goes to IDLE immediately;
  - all outputs return to their reset values;
  - the in-flight result is discarded and no `done` is issued.

## Test plan
- 0x40C00000 / 0x40000000 (6.0 / 2.0), `start` at cycle 0 → `done` at cycle 27, `res` = 0x40400000, all flags 0, `busy` high in cycles 1–26.
- 0x3F800000 / 0x40400000 (1 / 3) → `res` = 0x3EAAAAAB (round-up path). Also 0xC0000000 / 0x3F800000 → 0xC0000000.
- Special cases, each with `done` in cycle 1 and `busy` never high:
  - 0x3F800000 / 0x00000000 → 0x7F800000, `div_by_zero` = 1.
  - 0x00000000 / 0x00000000 → 0x7F800001, `nan` = 1.
  - 0x7F800000 / 0x7F800000 → 0x7F800001, `nan` = 1.
- Range limits:
  - 0x7F000000 / 0x3E800000 → 0x7F800000, `exp_overflow` = 1.
  - 0x00800000 / 0x40000000 → 0x00000000, `zero` = 1.
- `start` pulsed with new operands in cycle 10 of a running division → ignored; the original quotient is returned at cycle 27.
- `rst` asserted in cycle 12 of a division → outputs are at their reset values and `busy` = 0 immediately, with no `done`. A fresh 6.0 / 2.0 issued afterwards completes correctly in 27 cycles.

Source files
------------

// File: rtl/fp_div.sv
// Iterative binary32 divider: restoring division, one quotient bit per cycle,
// round-to-nearest-even, with the same flag set as the companion multiplier.
module fp_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] opd1,
    input  logic [31:0] opd2,
    output logic        busy,
    output logic        done,
    output logic [31:0] res,
    output logic        nan,
    output logic        zero,
    output logic        exp_overflow,
    output logic        div_by_zero
);
    typedef enum logic [1:0] {IDLE, DIV, RND} state_t;

    state_t             state_q, state_d;
    logic        [24:0] rem_q, rem_d;
    logic        [23:0] mb_q, mb_d;
    logic        [24:0] quo_q, quo_d;
    logic        [4:0]  cnt_q, cnt_d;
    logic signed [9:0]  exp_q, exp_d;
    logic               sign_q, sign_d;
    logic        [31:0] res_q, res_d;
    logic        [3:0]  flags_q, flags_d;  // {nan, zero, exp_overflow, div_by_zero}
    logic               done_q, done_d;

    logic [7:0]  e1, e2;
    logic [22:0] m1, m2;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special, sign_in;
    logic [23:0] ma, mb;
    logic        pre_shift, ge, inc, carry;
    logic [24:0] rem_sub;
    logic [22:0] mant;
    logic signed [9:0] e_fin;

    // Subnormals (exp = 0) are treated as zero regardless of mantissa.
    always_comb begin
        e1      = opd1[30:23];
        e2      = opd2[30:23];
        m1      = opd1[22:0];
        m2      = opd2[22:0];
        a_zero  = (e1 == 8'h00);
        b_zero  = (e2 == 8'h00);
        a_inf   = (e1 == 8'hFF) && (m1 == 23'd0);
        b_inf   = (e2 == 8'hFF) && (m2 == 23'd0);
        a_nan   = (e1 == 8'hFF) && (m1 != 23'd0);
        b_nan   = (e2 == 8'hFF) && (m2 != 23'd0);
        special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
        sign_in = opd1[31] ^ opd2[31];
        ma      = {1'b1, m1};
        mb      = {1'b1, m2};
        pre_shift = (ma < mb);
    end

    // State register plus every datapath and output flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            mb_q    <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
            state_q <= state_d;
            rem_q   <= rem_d;
            mb_q    <= mb_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !special) state_d = DIV;
            DIV:     if (cnt_q == 5'd24)    state_d = RND;
            RND:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        rem_d   = rem_q;
        mb_d    = mb_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        res_d   = res_q;
        flags_d = flags_q;
        done_d  = 1'b0;

        ge      = (rem_q >= {1'b0, mb_q});
        rem_sub = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
        inc     = quo_q[0] & ((rem_q != 25'd0) | quo_q[1]);
        {carry, mant} = {1'b0, quo_q[23:1]} + {23'd0, inc};
        e_fin   = exp_q + $signed({9'd0, carry});

        case (state_q)
            IDLE: if (start) begin
                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                    res_d = 32'h7F80_0001; flags_d = 4'b1000; done_d = 1'b1;
                end else if (b_zero && !a_zero && !a_inf) begin
                    res_d = {sign_in, 8'hFF, 23'd0}; flags_d = 4'b0001; done_d = 1'b1;
                end else if (a_zero || b_inf) begin
                    res_d = 32'd0; flags_d = 4'b0100; done_d = 1'b1;
                end else if (a_inf) begin
                    res_d = {sign_in, 8'hFF, 23'd0}; flags_d = 4'b0010; done_d = 1'b1;
                end else begin
                    // Normalise so the quotient lands in [1, 2).
                    rem_d  = pre_shift ? {ma, 1'b0} : {1'b0, ma};
                    exp_d  = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127
                             - (pre_shift ? 10'sd1 : 10'sd0);
                    mb_d   = mb;
                    sign_d = sign_in;
                    quo_d  = '0;
                    cnt_d  = '0;
                end
            end
            DIV: begin
                rem_d = {rem_sub[23:0], 1'b0};
                quo_d = {quo_q[23:0], ge};
                cnt_d = cnt_q + 5'd1;
            end
            RND: begin
                done_d = 1'b1;
                if (e_fin >= 10'sd255) begin
                    res_d = {sign_q, 8'hFF, 23'd0}; flags_d = 4'b0010;
                end else if (e_fin <= 10'sd0) begin
                    res_d = 32'd0; flags_d = 4'b0100;
                end else begin
                    res_d = {sign_q, e_fin[7:0], mant}; flags_d = 4'b0000;
                end
            end
            default: ;
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign res          = res_q;
    assign nan          = flags_q[3];
    assign zero         = flags_q[2];
    assign exp_overflow = flags_q[1];
    assign div_by_zero  = flags_q[0];
endmodule

// File: tb/tb_fp_div.sv
// Directed-vector bench for fp_div: latency, busy window, results, flags,
// ignored mid-run start and asynchronous reset mid-division.
module tb_fp_div;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] opd1, opd2;
    logic        busy, done, nan, zero, exp_overflow, div_by_zero;
    logic [31:0] res;

    int n_checks = 0;
    int n_errors = 0;

    fp_div dut (
        .clk(clk), .rst(rst), .start(start), .opd1(opd1), .opd2(opd2),
        .busy(busy), .done(done), .res(res), .nan(nan), .zero(zero),
        .exp_overflow(exp_overflow), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // flags order: {nan, zero, exp_overflow, div_by_zero}
    // inj > 0 pulses a competing start in that cycle; rc > 0 asserts rst in that cycle.
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef, input int elat,
                       input int inj, input int rc);
        int  cyc;
        int  busy_cnt;
        int  late_done;
        bit  got;
        opd1  = a;
        opd2  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        opd1  = 32'h4120_0000;
        opd2  = 32'h3F80_0000;
        cyc = 1; busy_cnt = 0; got = 1'b0;
        while (!got && cyc <= 60) begin
            if (cyc == rc) begin
                rst = 1'b1;
                #1;
                check({tag, " rst busy"}, {31'd0, busy}, 32'd0);
                check({tag, " rst done"}, {31'd0, done}, 32'd0);
                check({tag, " rst res"}, res, 32'd0);
                check({tag, " rst flags"}, {28'd0, nan, zero, exp_overflow, div_by_zero}, 32'd0);
                #1 rst = 1'b0;
                late_done = 0;
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk); #1;
                    if (done || busy) late_done++;
                end
                check({tag, " no done after rst"}, late_done, 0);
                return;
            end
            if (cyc == inj) begin
                start = 1'b1;
                opd1  = 32'h3F80_0000;
                opd2  = 32'h4040_0000;
            end
            if (busy) busy_cnt++;
            if (done) got = 1'b1;
            else begin
                @(posedge clk); #1;
                start = 1'b0;
                cyc++;
            end
        end
        check({tag, " done seen"}, {31'd0, got}, 32'd1);
        check({tag, " latency"}, cyc, elat);
        check({tag, " busy cycles"}, busy_cnt, elat - 1);
        check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
        check({tag, " res"}, res, er);
        check({tag, " flags"}, {28'd0, nan, zero, exp_overflow, div_by_zero}, {28'd0, ef});
        @(posedge clk); #1;
        check({tag, " done pulse width"}, {31'd0, done}, 32'd0);
        check({tag, " res hold"}, res, er);
        check({tag, " flags hold"}, {28'd0, nan, zero, exp_overflow, div_by_zero}, {28'd0, ef});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opd1 = '0; opd2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset res", res, 32'd0);
        check("reset flags", {28'd0, nan, zero, exp_overflow, div_by_zero}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run("6/2",      32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 27, 0, 0);
        run("1/3",      32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 27, 0, 0);
        run("-2/1",     32'hC000_0000, 32'h3F80_0000, 32'hC000_0000, 4'b0000, 27, 0, 0);
        run("1/0",      32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0001, 1, 0, 0);
        run("0/0",      32'h0000_0000, 32'h0000_0000, 32'h7F80_0001, 4'b1000, 1, 0, 0);
        run("inf/inf",  32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0001, 4'b1000, 1, 0, 0);
        run("-1/0",     32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 4'b0001, 1, 0, 0);
        run("0/2",      32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 4'b0100, 1, 0, 0);
        run("-inf/2",   32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0010, 1, 0, 0);
        run("ovf",      32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 4'b0010, 27, 0, 0);
        run("uflow",    32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0100, 27, 0, 0);
        run("ignore",   32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 27, 10, 0);
        run("rst mid",  32'h40C0_0000, 32'h4000_0000, 32'h0000_0000, 4'b0000, 27, 0, 12);
        run("after rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 27, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
